// File: rtl/cva5_types.sv
// Shared walker types: FSM states, PTE permission bundle and
// PTE field positions used by the Sv32 page walker.
package cva5_types;
    typedef enum logic [2:0] {
        IDLE,
        L1_REQ,
        L1_WAIT,
        L0_REQ,
        L0_WAIT,
        RESP
    } ptw_state_t;

    typedef struct packed {
        logic d;
        logic a;
        logic g;
        logic u;
        logic x;
        logic w;
        logic r;
    } pte_perms_t;

    localparam int PTE_V = 0;
    localparam int PTE_R = 1;
    localparam int PTE_W = 2;
    localparam int PTE_X = 3;
    localparam int PTE_U = 4;
    localparam int PTE_G = 5;
    localparam int PTE_A = 6;
    localparam int PTE_D = 7;

    localparam int PPN0_LSB = 10;
    localparam int PPN0_MSB = 19;
    localparam int PPN1_LSB = 20;
    localparam int PPN1_MSB = 29;

    localparam logic [1:0] PRIV_U = 2'b00;
endpackage

// File: rtl/perms_check.sv
// Leaf PTE access check: access type, MXR, SUM and
// user/supervisor ownership rules.
module perms_check
    import cva5_types::*;
(
    input  pte_perms_t perms,
    input  logic       rnw,
    input  logic       execute,
    input  logic       mxr,
    input  logic       sum,
    input  logic [1:0] privilege,
    output logic       pass
);
    logic user_ok;
    logic access_ok;
    logic unused_g;

    assign unused_g = perms.g;

    always_comb begin
        user_ok   = 1'b0;
        access_ok = 1'b0;
        if (privilege == PRIV_U)
            user_ok = perms.u;
        else
            user_ok = ~perms.u | (sum & ~execute);
        if (execute)
            access_ok = perms.x;
        else if (rnw)
            access_ok = perms.r | (mxr & perms.x);
        else
            access_ok = perms.w & perms.d;
    end

    assign pass = user_ok & access_ok & perms.a;
endmodule

// File: rtl/sv32_page_walker.sv
// Sv32 two-level page-table walker: one refill or one fault
// pulse per accepted TLB miss, with abortable walks.
module sv32_page_walker
    import cva5_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        request,
    input  logic [31:0] virtual_address,
    input  logic        rnw,
    input  logic        execute,
    output logic        ready,
    input  logic        abort,
    input  logic [19:0] satp_ppn,
    input  logic        mxr,
    input  logic        sum,
    input  logic [1:0]  privilege,
    output logic        write_entry,
    output logic [19:0] upper_physical_address,
    output logic        superpage,
    output pte_perms_t  perms,
    output logic        is_fault,
    output logic        mem_request,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    ptw_state_t  state, next_state;
    logic [9:0]  vpn0, vpn0_n;
    logic        rnw_r, rnw_n;
    logic        execute_r, execute_n;
    logic        abort_pending, abort_pending_n;
    logic [31:0] mem_addr_n;
    logic [19:0] upa_n;
    logic        superpage_n, write_entry_n, is_fault_n;
    pte_perms_t  perms_n, pte, pte_check;
    logic        level1, leaf, perm_ok, fault, unused_bits;

    assign unused_bits = ^{virtual_address[11:0], mem_rdata[9:8]};

    assign pte = '{d: mem_rdata[PTE_D], a: mem_rdata[PTE_A],
                   g: mem_rdata[PTE_G], u: mem_rdata[PTE_U],
                   x: mem_rdata[PTE_X], w: mem_rdata[PTE_W],
                   r: mem_rdata[PTE_R]};

    // A is faulted separately, so the checker only judges access rights
    assign pte_check = '{d: pte.d, a: 1'b1, g: pte.g, u: pte.u,
                         x: pte.x, w: pte.w, r: pte.r};

    perms_check u_perms_check (
        .perms     (pte_check),
        .rnw       (rnw_r),
        .execute   (execute_r),
        .mxr       (mxr),
        .sum       (sum),
        .privilege (privilege),
        .pass      (perm_ok)
    );

    assign level1 = (state == L1_WAIT);
    assign leaf   = pte.r | pte.x;
    assign fault  = ~mem_rdata[PTE_V]
                  | (~pte.r & pte.w)
                  | (|mem_rdata[31:30])
                  | (leaf & ~pte.a)
                  | (leaf & ~rnw_r & ~execute_r & ~pte.d)
                  | (leaf & ~perm_ok)
                  | (level1 & leaf & (|mem_rdata[PPN0_MSB:PPN0_LSB]))
                  | (~level1 & ~leaf);

    assign ready       = (state == IDLE);
    assign mem_request = (state == L1_REQ) || (state == L0_REQ);

    always_comb begin
        next_state      = state;
        vpn0_n          = vpn0;
        rnw_n           = rnw_r;
        execute_n       = execute_r;
        abort_pending_n = abort_pending;
        mem_addr_n      = mem_addr;
        upa_n           = upper_physical_address;
        superpage_n     = superpage;
        perms_n         = perms;
        write_entry_n   = 1'b0;
        is_fault_n      = 1'b0;
        unique case (state)
            IDLE: begin
                if (request && !abort) begin
                    vpn0_n     = virtual_address[21:12];
                    rnw_n      = rnw;
                    execute_n  = execute;
                    mem_addr_n = {satp_ppn, virtual_address[31:22], 2'b00};
                    next_state = L1_REQ;
                end
            end
            L1_REQ, L0_REQ: begin
                if (abort)
                    abort_pending_n = 1'b1;
                if (mem_ack)
                    next_state = (state == L1_REQ) ? L1_WAIT : L0_WAIT;
            end
            L1_WAIT, L0_WAIT: begin
                if (abort)
                    abort_pending_n = 1'b1;
                if (mem_rvalid) begin
                    if (abort || abort_pending) begin
                        abort_pending_n = 1'b0;
                        next_state      = IDLE;
                    end else if (fault) begin
                        is_fault_n = 1'b1;
                        next_state = RESP;
                    end else if (!leaf) begin
                        mem_addr_n = {mem_rdata[PPN1_MSB:PPN0_LSB], vpn0, 2'b00};
                        next_state = L0_REQ;
                    end else begin
                        write_entry_n = 1'b1;
                        perms_n       = pte;
                        superpage_n   = level1;
                        upa_n         = level1
                            ? {mem_rdata[PPN1_MSB:PPN1_LSB], 10'b0}
                            : mem_rdata[PPN1_MSB:PPN0_LSB];
                        next_state    = RESP;
                    end
                end
            end
            RESP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                  <= IDLE;
            vpn0                   <= '0;
            rnw_r                  <= 1'b0;
            execute_r              <= 1'b0;
            abort_pending          <= 1'b0;
            mem_addr               <= '0;
            upper_physical_address <= '0;
            superpage              <= 1'b0;
            perms                  <= '0;
            write_entry            <= 1'b0;
            is_fault               <= 1'b0;
        end else begin
            state                  <= next_state;
            vpn0                   <= vpn0_n;
            rnw_r                  <= rnw_n;
            execute_r              <= execute_n;
            abort_pending          <= abort_pending_n;
            mem_addr               <= mem_addr_n;
            upper_physical_address <= upa_n;
            superpage              <= superpage_n;
            perms                  <= perms_n;
            write_entry            <= write_entry_n;
            is_fault               <= is_fault_n;
        end
    end

    a_request_when_ready: assert property (
        @(posedge clk) disable iff (rst) request |-> ready
    );
endmodule

// File: tb/tb_sv32_page_walker.sv
// Randomised and directed bench for sv32_page_walker against
// a software-style Sv32 walk over a sparse memory model.
module tb_sv32_page_walker;
    import cva5_types::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        request = 1'b0;
    logic [31:0] virtual_address = '0;
    logic        rnw = 1'b1;
    logic        execute = 1'b0;
    logic        ready;
    logic        abort = 1'b0;
    logic [19:0] satp_ppn = '0;
    logic        mxr = 1'b0;
    logic        sum = 1'b0;
    logic [1:0]  privilege = 2'b01;
    logic        write_entry;
    logic [19:0] upper_physical_address;
    logic        superpage;
    pte_perms_t  perms;
    logic        is_fault;
    logic        mem_request;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    always #5 clk = ~clk;

    sv32_page_walker dut (
        .clk                    (clk),
        .rst                    (rst),
        .request                (request),
        .virtual_address        (virtual_address),
        .rnw                    (rnw),
        .execute                (execute),
        .ready                  (ready),
        .abort                  (abort),
        .satp_ppn               (satp_ppn),
        .mxr                    (mxr),
        .sum                    (sum),
        .privilege              (privilege),
        .write_entry            (write_entry),
        .upper_physical_address (upper_physical_address),
        .superpage              (superpage),
        .perms                  (perms),
        .is_fault               (is_fault),
        .mem_request            (mem_request),
        .mem_addr               (mem_addr),
        .mem_ack                (mem_ack),
        .mem_rvalid             (mem_rvalid),
        .mem_rdata              (mem_rdata)
    );

    int vecs = 0;
    int errs = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit [31:0] mem [bit [31:0]];

    int stall = 0, stall_max = 2, rv_min = 1, rv_max = 3, rv_cnt = 0;
    int rd_idx = 0, last_rv_cyc = -1, abort_cyc = 1 << 30;
    int resp_cnt = 0, resp_cyc = 0, req_cyc = 0;
    logic [31:0] rd_data = '0, hold_addr = '0;
    bit hold_valid = 0;

    bit          m_fault, m_sp;
    logic [19:0] m_upa;
    logic [6:0]  m_perms;
    logic [31:0] m_a1, m_a2;
    int          m_nreads;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Sv32 walk done the way software would, over the bench memory
    task automatic model_walk(input logic [31:0] va, input bit ld, input bit ex);
        logic [31:0] pte, addr;
        int level;
        bit done, ok, store;
        m_fault = 0; m_sp = 0; m_upa = '0; m_perms = '0; m_a2 = '0;
        addr = satp_ppn * 4096 + (va >> 22) * 4;
        m_a1 = addr;
        m_nreads = 0;
        level = 1;
        done = 0;
        store = !ld && !ex;
        while (!done) begin
            pte = rd_mem(addr);
            m_nreads++;
            if (!pte[0] || (!pte[1] && pte[2]) || (pte >> 30) != 0) begin
                m_fault = 1;
                done = 1;
            end else if (pte[1] || pte[3]) begin
                ok = pte[6] && !(store && !pte[7]);
                if (ex) ok = ok && pte[3];
                else if (ld) ok = ok && (pte[1] || (mxr && pte[3]));
                else ok = ok && pte[2];
                if (privilege == 2'b00) ok = ok && pte[4];
                else if (pte[4]) ok = ok && sum && !ex;
                if (level == 1 && ((pte >> 10) % 1024) != 0) ok = 0;
                m_fault = !ok;
                if (ok) begin
                    m_sp = (level == 1);
                    m_perms = 7'((pte >> 1) % 128);
                    m_upa = (level == 1) ? 20'(((pte >> 20) % 1024) * 1024)
                                         : 20'((pte >> 10) % (1 << 20));
                end
                done = 1;
            end else if (level == 0) begin
                m_fault = 1;
                done = 1;
            end else begin
                addr = ((pte >> 10) % (1 << 20)) * 4096 + ((va >> 12) % 1024) * 4;
                m_a2 = addr;
                level = 0;
            end
        end
    endtask

    function automatic logic [31:0] rand_pte(input bit ptr);
        logic [31:0] p;
        p = $urandom;
        p[0] = ($urandom % 8) != 0;
        p[6] = ($urandom % 8) != 0;
        p[7] = ($urandom % 4) != 0;
        if (ptr) p[3:1] = 3'b000;
        if (($urandom % 8) != 0) p[31:30] = 2'b00;
        return p;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Memory responder: drives ack/rvalid just after each clock edge
    initial begin
        forever begin
            tick;
            mem_ack = 1'b0;
            mem_rvalid = 1'b0;
            if (rst) begin
                rv_cnt = 0;
                hold_valid = 0;
            end else if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = rd_data;
                    last_rv_cyc = cyc;
                end
            end else if (mem_request) begin
                if (hold_valid) chk("addr_hold", mem_addr, hold_addr);
                hold_addr = mem_addr;
                hold_valid = 1;
                if (stall > 0) begin
                    stall--;
                end else begin
                    mem_ack = 1'b1;
                    chk("extra_read", rd_idx < m_nreads, 1);
                    chk("mem_addr", mem_addr, (rd_idx == 0) ? m_a1 : m_a2);
                    rd_idx++;
                    rd_data = rd_mem(mem_addr);
                    rv_cnt = $urandom_range(rv_max, rv_min);
                    stall = $urandom_range(stall_max, 0);
                    hold_valid = 0;
                end
            end
        end
    end

    // Output compare: every refill/fault pulse is checked against the model
    initial begin
        bit disc;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (write_entry || is_fault) begin
                    resp_cnt++;
                    resp_cyc = cyc;
                    disc = abort_cyc <= last_rv_cyc;
                    chk("resp_kind", {write_entry, is_fault},
                        disc ? 2'b00 : (m_fault ? 2'b01 : 2'b10));
                    if (write_entry && !disc && !m_fault)
                        chk("refill", {upper_physical_address, superpage, perms},
                            {m_upa, m_sp, m_perms});
                end
            end
        end
    end

    task automatic recover;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic walk(input logic [31:0] va, input bit ld, input bit ex, input int abort_after);
        int n;
        bit disc;
        model_walk(va, ld, ex);
        rd_idx = 0;
        resp_cnt = 0;
        last_rv_cyc = -1;
        abort_cyc = 1 << 30;
        n = 0;
        while (!ready && n < 50) begin
            tick;
            n++;
        end
        request = 1'b1;
        virtual_address = va;
        rnw = ld;
        execute = ex;
        req_cyc = cyc;
        tick;
        request = 1'b0;
        if (abort_after > 0) begin
            repeat (abort_after - 1) tick;
            abort = 1'b1;
            abort_cyc = cyc;
            tick;
            abort = 1'b0;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 300);
        chk("walk_done", ready, 1);
        disc = abort_cyc <= last_rv_cyc;
        chk("resp_count", resp_cnt, disc ? 0 : 1);
        if (!disc) chk("reads", rd_idx, m_nreads);
        if (disc) chk("ready_after_abort", cyc - last_rv_cyc, 1);
        else if (abort_after < 0) chk("ready_after_resp", cyc - resp_cyc, 1);
        tick;
        if (!ready) recover;
    endtask

    task automatic setup_t1(input logic [31:0] l0);
        mem.delete();
        satp_ppn = 20'h00100;
        privilege = 2'b01;
        mxr = 0;
        sum = 0;
        mem[32'h0010_0004] = 32'h0000_0801;
        mem[32'h0000_2004] = l0;
    endtask

    initial begin
        int n;
        logic [31:0] va, a1, a2, l1;
        bit ld, ex, ptr;
        int ab;

        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] va, a1, a2, l1;
        bit ld, ex, ptr;
        int ab;

        tick;
        tick;
        chk("rst_ready", ready, 1);
        chk("rst_outputs", {mem_request, write_entry, is_fault, superpage}, 0);
        chk("rst_regs", {mem_addr, upper_physical_address, perms}, 0);
        rst = 1'b0;
        tick;
        chk("idle_ready", {ready, mem_request}, 2'b10);

        // pointer then 4 KiB leaf
        setup_t1(32'h0123_40CF);
        walk(32'h0040_1234, 1, 0, -1);
        chk("pin_t1", {m_fault, m_upa, m_sp, m_perms, m_a2},
            {1'b0, 20'h048D0, 1'b0, 7'h67, 32'h0000_2004});

        // aligned superpage, zero-wait memory
        stall_max = 0; rv_min = 1; rv_max = 1; stall = 0;
        mem[32'h0010_0004] = 32'h2000_00CF;
        walk(32'h0040_1234, 1, 0, -1);
        chk("pin_super", {m_fault, m_upa, m_sp, 8'(m_nreads)},
            {1'b0, 20'h80000, 1'b1, 8'd1});
        chk("super_latency", resp_cyc - req_cyc, 3);

        // misaligned superpage
        mem[32'h0010_0004] = 32'h2000_04CF;
        walk(32'h0040_1234, 1, 0, -1);
        chk("pin_misaligned", m_fault, 1);

        // store to clean page faults, load succeeds
        setup_t1(32'h0123_404F);
        walk(32'h0040_1234, 0, 0, -1);
        chk("pin_store_clean", m_fault, 1);
        walk(32'h0040_1234, 1, 0, -1);
        chk("pin_load_clean", {m_fault, m_perms}, {1'b0, 7'h27});

        // abort in L0_WAIT, data arrives 3 cycles later
        setup_t1(32'h0123_40CF);
        rv_min = 4; rv_max = 4;
        walk(32'h0040_1234, 1, 0, 7);
        chk("abort_no_resp", resp_cnt, 0);
        rv_min = 1; rv_max = 1;
        walk(32'h0040_1234, 1, 0, -1);

        // request with abort in the same cycle is dropped
        request = 1'b1; abort = 1'b1;
        tick;
        request = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("abort_with_req", {ready, mem_request}, 2'b10);
        tick;

        // ack held off for 5 cycles
        stall = 5;
        walk(32'h0040_1234, 1, 0, -1);

        // reset in the middle of L1_WAIT
        rv_min = 6; rv_max = 6; stall = 0;
        model_walk(32'h0040_1234, 1, 0);
        rd_idx = 0; resp_cnt = 0; last_rv_cyc = -1; abort_cyc = 1 << 30;
        request = 1'b1; virtual_address = 32'h0040_1234;
        tick;
        request = 1'b0;
        n = 0;
        while (rd_idx < 1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_walk_acked", rd_idx, 1);
        tick;
        rst = 1'b1;
        #1;
        chk("rst_midwalk", {ready, mem_request, write_entry, is_fault}, 4'b1000);
        tick;
        tick;
        rst = 1'b0;
        tick;
        chk("rst_no_resp", resp_cnt, 0);
        rv_min = 1; rv_max = 2;
        walk(32'h0040_1234, 1, 0, -1);

        // randomised walks
        for (int i = 0; i < 250; i++) begin
            mem.delete();
            satp_ppn = 20'($urandom);
            privilege = 2'($urandom % 2);
            mxr = 1'($urandom);
            sum = 1'($urandom);
            va = $urandom;
            ex = ($urandom % 4) == 0;
            ld = ex ? 1'b1 : 1'($urandom);
            a1 = satp_ppn * 4096 + (va >> 22) * 4;
            ptr = 1'($urandom);
            l1 = rand_pte(ptr);
            if (!ptr && ($urandom % 4) != 0) l1[19:10] = '0;
            mem[a1] = l1;
            if (l1[3:1] == 3'b000) begin
                a2 = ((l1 >> 10) % (1 << 20)) * 4096 + ((va >> 12) % 1024) * 4;
                mem[a2] = rand_pte(($urandom % 8) == 0);
            end
            stall_max = $urandom % 3;
            rv_min = 1;
            rv_max = 1 + $urandom % 3;
            stall = 0;
            ab = (($urandom % 6) == 0) ? 1 + $urandom % 8 : -1;
            walk(va, ld, ex, ab);
        end

        tick;
        tick;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/sv32_page_walker.md
Name: sv32_page_walker

Overview:
- Hardware Sv32 page-table walker. It is the responder on the TLB-miss interface: it accepts a miss request from a data or instruction TLB and walks the two-level page table in memory.
- On success it returns one refill packet: write_entry pulse, upper physical address, superpage flag and PTE permissions. On any failure it returns a single-cycle fault.
- Sits between the TLBs and a load-only memory port, normally arbitrated with the data cache.

Parameters:
- NONE_REQUIRED, n/a. The block is fixed to Sv32: 2 levels, 4-byte PTEs, 32-bit physical addresses.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- request  in  1  TLB miss strobe, one cycle; only sent while ready=1
- virtual_address  in  32  faulting VA, sampled with request
- rnw  in  1  1=load, 0=store; sampled with request
- execute  in  1  instruction fetch; sampled with request
- ready  out  1  walker idle
- abort  in  1  discard the current walk (pipeline flush)
- satp_ppn  in  20  root page-table PPN
- mxr, sum  in  1 each  status bits
- privilege  in  2  effective privilege
- write_entry  out  1  one-cycle refill pulse
- upper_physical_address  out  20  {ppn1,ppn0}; ppn0 is 0 for superpages
- superpage  out  1  leaf found at level 1
- perms  out  pte_perms_t  {d,a,g,u,x,w,r}, valid with write_entry
- is_fault  out  1  one-cycle page-fault pulse
- mem_request  out  1  read request, held until mem_ack
- mem_addr  out  32  word-aligned PTE address
- mem_ack  in  1  request accepted
- mem_rvalid  in  1  read data valid (exactly one per ack)
- mem_rdata  in  32  PTE

Behaviour:
Reset:
- state=IDLE; ready=1.
- mem_request, write_entry and is_fault are 0; all other registered outputs are 0.
- abort_pending=0.

States: IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, RESP.
- IDLE: on request, latch va/rnw/execute. Go to L1_REQ and drive mem_addr={satp_ppn, va[31:22], 2'b00}. ready=0 in every other state.
- Lx_REQ: mem_request=1 and mem_addr held stable until mem_ack, then go to Lx_WAIT. The request is never withdrawn, even after abort.
- Lx_WAIT: on mem_rvalid, evaluate the PTE in that cycle; results are registered.
- Fault conditions, checked in this order:
  - V=0
  - R=0 & W=1
  - mem_rdata[31:30]≠0 (PPN outside 32-bit space)
  - leaf with A=0
  - store to a leaf with D=0
  - perms_check fails (using rnw, execute, mxr, sum, privilege)
  - L1 leaf with PTE ppn0 (rdata[19:10]) ≠0, i.e. a misaligned superpage
  - L0 PTE that is non-leaf
- Any fault: go to RESP with fault=1.
- L1 non-leaf: mem_addr={rdata[29:10], va[21:12], 2'b00}, go to L0_REQ.
- Leaf (R|X): capture perms and PPN; superpage=(level==1); go to RESP.
- RESP (exactly one cycle):
  - write_entry=1 for a success, or is_fault=1 for a fault; never both.
  - Then go to IDLE; ready=1 on the next cycle.
  - Outputs are registered, so they are glitch-free.

Latency:
- Minimum, superpage hit: request@T, mem_request@T+1, ack@T+1, rvalid@T+2, write_entry@T+3.
- Each additional memory latency cycle adds one cycle.

Abort:
- In IDLE or RESP: no effect. RESP still completes.
- In REQ or WAIT: set abort_pending. The in-flight read completes (ack then rvalid). After the data returns, go to IDLE with no write_entry and no is_fault.
- abort in the same cycle as mem_rvalid: result discarded.
- abort in the same cycle as request in IDLE: request ignored.

Other rules:
- request while not ready: ignored. This is an assertion error.
- rst mid-walk: immediate return to IDLE. The memory side must also be reset.

Decomposition:
- Shared types package cva5_types:
  - ptw_state_t enum
  - PTE bit-position constants (V=0 … D=7, PPN0=19:10, PPN1=29:20)
  - reuse the existing pte_perms_t
- Sub-module: reuse the existing perms_check, one instance, fed from mem_rdata with a=1.
- The walker must not duplicate its logic.

Test Plan:
- satp_ppn=0x00100, va=0x0040_1234, L1 PTE@0x0010_0004=0x0000_0801 (pointer), L0 PTE@0x0000_2004=0x0123_40CF, load, S-mode → write_entry=1, upper_physical_address=0x048D0, superpage=0, perms r/w/x/a/d set.
- Same va, L1 PTE=0x2000_00CF (aligned superpage) → write_entry@T+3 with 0-wait memory, superpage=1, upper_physical_address=0x80000, only 1 mem_request.
- L1 PTE=0x2000_04CF (ppn0≠0) → is_fault=1 one cycle, write_entry never asserted.
- Store to a leaf with D=0 (0x0123_404F) → is_fault=1. The same PTE with rnw=1 → write_entry=1.
- abort asserted while in L0_WAIT, mem_rvalid 3 cycles later → no write_entry/is_fault, ready=1 the cycle after rvalid, next request walks normally.
- Hold mem_ack low 5 cycles → mem_request and mem_addr stable all 5 cycles. rst pulsed mid-L1_WAIT → ready=1, mem_request=0 immediately.
